icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache sitting directly upstream of the instruction fetch queue.
- Accepts a fetch PC and returns one aligned 128-bit line, i.e. four 32-bit instructions.
- Serves hits from internal tag/data arrays.
- Handles misses with a line-fill state machine toward a backing memory port.
- Honours the fetch queue's abort on branch/jump redirect.

Parameters:
- LINES, 64, number of cache lines; power of two, >= 2. IDX_W = log2(LINES).
- TAG_W, 28 - IDX_W, tag width: pc[31:4+IDX_W].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- icache_pc_in  input  32  fetch address; pc[3:0] ignored (line aligned).
- icache_rd_en  input  1  fetch request, sampled only in IDLE.
- icache_abort  input  1  cancel the outstanding request; no response for it.
- icache_dout  output  128  line data; word0 = [31:0] ... word3 = [127:96].
- icache_dout_valid  output  1  single-cycle pulse; icache_dout valid that cycle.
- mem_addr  output  32  line-aligned fill address; [3:0] = 0.
- mem_rd_en  output  1  single-cycle fill request pulse.
- mem_dout  input  128  fill line from memory.
- mem_dout_valid  input  1  fill data valid; arbitrary latency >= 1 after mem_rd_en.

Behaviour:
- Reset (sync, active-high): all valid bits cleared; FSM to IDLE; icache_dout = 0, icache_dout_valid = 0, mem_addr = 0, mem_rd_en = 0. Reset mid-fill drops the fill; a late mem_dout_valid is ignored in IDLE.
- Address split: index = pc[4+IDX_W-1:4], tag = pc[31:4+IDX_W].
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
- IDLE: rd_en=1 and abort=0 -> capture pc into req_pc_r, go to LOOKUP. rd_en=1 with abort=1 -> request ignored, stay IDLE.
- LOOKUP: arrays read at req index.
  - Hit: dout_valid=1 with the line this cycle, go to IDLE. Hit latency is request cycle + 1.
  - Miss: go to MISS_REQ.
  - abort in LOOKUP: no dout_valid, go to IDLE.
- MISS_REQ: mem_rd_en=1 for exactly one cycle, mem_addr = {req_pc_r[31:4],4'b0}; go to MISS_WAIT. mem_addr holds its value until the next MISS_REQ.
- MISS_WAIT: on mem_dout_valid, write data, tag and valid=1 at the index, go to RESP.
- RESP: dout_valid=1 with the fill line; go to IDLE.
- Abort during MISS_REQ/MISS_WAIT:
  - Set internal aborted_r flag.
  - Fill still completes and the line is still installed, so memory stays consistent.
  - RESP is skipped, no dout_valid; go to IDLE.
  - aborted_r cleared on entry to IDLE.
- Abort in RESP cycle: dout_valid suppressed that cycle.
- Exactly one request outstanding. rd_en outside IDLE is ignored, including the dout_valid cycle. Peak hit throughput is one line per 2 cycles.
- Write into the index being looked up: line installed at the end of MISS_WAIT; the next lookup sees the new tag.
- icache_dout holds its last driven value when dout_valid=0.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - stat_hits increments on each LOOKUP hit that is not aborted.
  - stat_misses increments on each MISS_REQ entry.
  - Both are cleared by rst and wrap modulo 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: after rst, pc=0x00000040, rd_en=1; memory returns 0x33333333_22222222_11111111_00000000 three cycles after mem_rd_en -> mem_rd_en pulse with mem_addr=0x40, then one dout_valid pulse with that line, 1 cycle after mem_dout_valid.
- Hit: repeat pc=0x0000004C -> dout_valid exactly 1 cycle after the request, same line, no mem_rd_en.
- Conflict (LINES=64): fetch 0x40, then 0x440 (same index 4, different tag) -> miss, refill. Re-fetching 0x40 then misses again.
- Abort during MISS_WAIT for pc=0x80 -> no dout_valid. Next fetch of 0x80 hits with latency 1.
- rd_en+abort same cycle in IDLE -> no LOOKUP, no mem_rd_en, no dout_valid. rd_en held high through the dout_valid cycle -> second request accepted only the cycle after.
- rst asserted in MISS_WAIT, then mem_dout_valid arrives -> no array write, no dout_valid. Later fetch of the same pc misses. With ICACHE_STATS_EN, stat_hits=0 and stat_misses=0 right after rst.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory signals of the direct-mapped instruction cache.
// slave = cache side, master = fetch queue / memory side.
interface icache_dm_if;
    logic [31:0]  icache_pc_in;
    logic         icache_rd_en;
    logic         icache_abort;
    logic [127:0] icache_dout;
    logic         icache_dout_valid;
    logic [31:0]  mem_addr;
    logic         mem_rd_en;
    logic [127:0] mem_dout;
    logic         mem_dout_valid;

    modport slave (
        input  icache_pc_in, icache_rd_en, icache_abort, mem_dout, mem_dout_valid,
        output icache_dout, icache_dout_valid, mem_addr, mem_rd_en
    );

    modport master (
        output icache_pc_in, icache_rd_en, icache_abort, mem_dout, mem_dout_valid,
        input  icache_dout, icache_dout_valid, mem_addr, mem_rd_en
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache returning one 128-bit line per fetch.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_dm #(
    parameter int LINES = 64,
    parameter int TAG_W = 28 - $clog2(LINES)
) (
    input  logic         clk,
    input  logic         rst,
    icache_dm_if.slave   bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [27:0]      r_req_pc;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [127:0]     r_data [LINES];
    logic             r_aborted;
    logic [127:0]     r_dout;
    logic [31:0]      r_mem_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [127:0]     w_line;
    logic             w_dout_valid;
    logic             w_fill;
    logic             w_accept;
    logic             w_unused_pc_lo;

    assign w_idx          = r_req_pc[IDX_W-1:0];
    assign w_tag          = r_req_pc[27:IDX_W];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line         = r_data[w_idx];
    assign w_fill         = (r_state == S_MISS_WAIT) && bus.mem_dout_valid;
    assign w_accept       = (r_state == S_IDLE) && bus.icache_rd_en && !bus.icache_abort;
    assign w_unused_pc_lo = ^bus.icache_pc_in[3:0];

    always_comb begin
        w_next       = r_state;
        w_dout_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (bus.icache_abort) begin
                    w_next = S_IDLE;
                end else if (w_hit) begin
                    w_dout_valid = 1'b1;
                    w_next       = S_IDLE;
                end else begin
                    w_next = S_MISS_REQ;
                end
            end
            S_MISS_REQ: w_next = S_MISS_WAIT;
            S_MISS_WAIT: begin
                // An aborted fill still installs the line but skips the response.
                if (bus.mem_dout_valid)
                    w_next = (r_aborted || bus.icache_abort) ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                w_dout_valid = !bus.icache_abort;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_aborted  <= 1'b0;
            r_dout     <= '0;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE)
                r_aborted <= 1'b0;
            else if (bus.icache_abort && (r_state == S_MISS_REQ || r_state == S_MISS_WAIT))
                r_aborted <= 1'b1;
            if (w_fill) r_valid[w_idx] <= 1'b1;
            if (w_dout_valid) r_dout <= w_line;
            if (r_state == S_LOOKUP && w_next == S_MISS_REQ)
                r_mem_addr <= {r_req_pc, 4'b0000};
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_req_pc <= bus.icache_pc_in[31:4];
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.mem_dout;
        end
    end

    assign bus.icache_dout       = w_dout_valid ? w_line : r_dout;
    assign bus.icache_dout_valid = w_dout_valid;
    assign bus.mem_addr          = r_mem_addr;
    assign bus.mem_rd_en         = (r_state == S_MISS_REQ);

`ifdef ICACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            if (r_state == S_LOOKUP && w_hit && !bus.icache_abort)
                r_stat_hits <= r_stat_hits + 32'd1;
            if (r_state == S_MISS_REQ)
                r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: vector table of fetches plus abort/reset sequences.
module tb_icache_dm;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    icache_dm_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    icache_dm #(.LINES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] mline;
        int           lat;
        int           exp_nreq;
        logic [31:0]  exp_maddr;
        int           exp_dv1;
        logic [127:0] exp_line;
    } vec_t;

    localparam logic [127:0] L40  = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] L440 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    localparam logic [127:0] LF   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] L80  = 128'h80808080_81818181_82828282_83838383;
    localparam logic [127:0] L100 = 128'h10001000_10011001_10021002_10031003;
    localparam logic [127:0] L200 = 128'h20002000_20012001_20022002_20032003;
    localparam logic [127:0] L300 = 128'h30003000_30013001_30023002_30033003;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One fetch, observed for a fixed window; the bench plays the memory.
    task automatic fetch(input logic [31:0] pc, input logic [127:0] mline, input int lat,
                         input int abort_cyc, input int hold, input int rst_cyc, input bit abort_req,
                         output int nreq, output logic [31:0] maddr, output int ndv,
                         output int dv1, output int dv2, output logic [127:0] dline);
        int pend;
        nreq = 0; maddr = '0; ndv = 0; dv1 = -1; dv2 = -1; dline = '0; pend = -1;
        @(negedge clk);
        bus.icache_pc_in = pc;
        bus.icache_rd_en = 1'b1;
        bus.icache_abort = abort_req;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.mem_dout_valid = 1'b0;
            if (bus.mem_rd_en) begin
                nreq++;
                maddr = bus.mem_addr;
                pend  = lat;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_dout       = mline;
                    bus.mem_dout_valid = 1'b1;
                    pend = -1;
                end
            end
            bus.icache_rd_en = (c < hold);
            bus.icache_abort = (c == abort_cyc);
            rst              = (c == rst_cyc);
            #1;
            if (bus.icache_dout_valid) begin
                ndv++;
                if (dv1 < 0) dv1 = c;
                else if (dv2 < 0) dv2 = c;
                dline = bus.icache_dout;
            end
        end
        bus.icache_rd_en   = 1'b0;
        bus.icache_abort   = 1'b0;
        bus.mem_dout_valid = 1'b0;
        rst                = 1'b0;
    endtask

    vec_t vecs [6];
    int nreq, ndv, dv1, dv2;
    logic [31:0]  maddr;
    logic [127:0] dline;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.icache_pc_in   = '0;
        bus.icache_rd_en   = 1'b0;
        bus.icache_abort   = 1'b0;
        bus.mem_dout       = '0;
        bus.mem_dout_valid = 1'b0;

        vecs[0] = '{32'h0000_0040, L40,  3, 1, 32'h0000_0040, 6, L40};
        vecs[1] = '{32'h0000_004C, '0,   1, 0, 32'h0,         1, L40};
        vecs[2] = '{32'h0000_0440, L440, 1, 1, 32'h0000_0440, 4, L440};
        vecs[3] = '{32'h0000_0040, L40,  2, 1, 32'h0000_0040, 5, L40};
        vecs[4] = '{32'hFFFF_FFF4, LF,   1, 1, 32'hFFFF_FFF0, 4, LF};
        vecs[5] = '{32'hFFFF_FFFC, '0,   1, 0, 32'h0,         1, LF};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout_valid", 128'(bus.icache_dout_valid), 128'd0);
        chk("rst_dout", bus.icache_dout, 128'd0);
        chk("rst_mem_rd_en", 128'(bus.mem_rd_en), 128'd0);
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_stat_hits", 128'(stat_hits), 128'd0);
        chk("rst_stat_misses", 128'(stat_misses), 128'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].pc, vecs[i].mline, vecs[i].lat, 0, 1, 0, 1'b0,
                  nreq, maddr, ndv, dv1, dv2, dline);
            chk($sformatf("v%0d_nreq", i), 128'(nreq), 128'(vecs[i].exp_nreq));
            if (vecs[i].exp_nreq != 0)
                chk($sformatf("v%0d_maddr", i), 128'(maddr), 128'(vecs[i].exp_maddr));
            chk($sformatf("v%0d_ndv", i), 128'(ndv), 128'd1);
            chk($sformatf("v%0d_latency", i), 128'(dv1), 128'(vecs[i].exp_dv1));
            chk($sformatf("v%0d_line", i), dline, vecs[i].exp_line);
        end
        chk("dout_hold", bus.icache_dout, LF);
`ifdef ICACHE_STATS_EN
        chk("stat_hits", 128'(stat_hits), 128'd2);
        chk("stat_misses", 128'(stat_misses), 128'd4);
`endif

        // Abort while waiting on memory: line still installed, no response.
        fetch(32'h80, L80, 3, 3, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("abwait_nreq", 128'(nreq), 128'd1);
        chk("abwait_maddr", 128'(maddr), 128'h80);
        chk("abwait_ndv", 128'(ndv), 128'd0);
        fetch(32'h80, '0, 1, 0, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("abwait_rehit_nreq", 128'(nreq), 128'd0);
        chk("abwait_rehit_lat", 128'(dv1), 128'd1);
        chk("abwait_rehit_line", dline, L80);

        // Abort during lookup: nothing fetched, later fetch misses.
        fetch(32'h100, L100, 2, 1, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("ablook_nreq", 128'(nreq), 128'd0);
        chk("ablook_ndv", 128'(ndv), 128'd0);
        fetch(32'h100, L100, 2, 0, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("ablook_refetch_nreq", 128'(nreq), 128'd1);
        chk("ablook_refetch_lat", 128'(dv1), 128'd5);
        chk("ablook_refetch_line", dline, L100);

        // Abort in the response cycle.
        fetch(32'h200, L200, 1, 4, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("abresp_nreq", 128'(nreq), 128'd1);
        chk("abresp_ndv", 128'(ndv), 128'd0);
        fetch(32'h200, '0, 1, 0, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("abresp_rehit_lat", 128'(dv1), 128'd1);
        chk("abresp_rehit_line", dline, L200);

        // rd_en together with abort in IDLE is dropped.
        fetch(32'h500, L40, 1, 0, 1, 0, 1'b1, nreq, maddr, ndv, dv1, dv2, dline);
        chk("idleab_nreq", 128'(nreq), 128'd0);
        chk("idleab_ndv", 128'(ndv), 128'd0);

        // rd_en held through the response cycle: second request one cycle later.
        fetch(32'h4C, '0, 1, 0, 3, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("hold_ndv", 128'(ndv), 128'd2);
        chk("hold_dv1", 128'(dv1), 128'd1);
        chk("hold_dv2", 128'(dv2), 128'd3);
        chk("hold_line", dline, L40);

        // Reset during MISS_WAIT: late memory data must be dropped.
        fetch(32'h300, L300, 3, 0, 1, 3, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("rstfill_nreq", 128'(nreq), 128'd1);
        chk("rstfill_ndv", 128'(ndv), 128'd0);
        chk("rstfill_mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("rstfill_dout", bus.icache_dout, 128'd0);
`ifdef ICACHE_STATS_EN
        chk("rstfill_stat_hits", 128'(stat_hits), 128'd0);
        chk("rstfill_stat_misses", 128'(stat_misses), 128'd0);
`endif
        fetch(32'h300, L300, 1, 0, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("rstfill_refetch_nreq", 128'(nreq), 128'd1);
        chk("rstfill_refetch_line", dline, L300);
        fetch(32'h40, L40, 1, 0, 1, 0, 1'b0, nreq, maddr, ndv, dv1, dv2, dline);
        chk("rstfill_cold40_nreq", 128'(nreq), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
